// File: rtl/ts_sync_detector.sv
`default_nettype none
// ============================================================================
//  Module   : ts_sync_detector
//  Purpose  : Byte-level MPEG2-TS packet aligner. Hunts for SYNC_BYTE in a raw
//             byte stream, confirms it at PKT_LEN spacing, and once locked
//             forwards only aligned bytes with byte 0 of each packet marked by
//             `sync`. Drops lock after UNLOCK_COUNT consecutive bad sync slots
//             and keeps a saturating count of lock-loss events.
//  Ports    : clk              - rising-edge clock
//             reset_n          - asynchronous active-low reset
//             valid_in         - data_in carries a byte this cycle
//             data_in[7:0]     - raw TS byte
//             en_reset_counter - synchronous clear of sync_loss_count
//             valid            - aligned byte valid (registered)
//             sync             - output byte is byte 0 of a packet (registered)
//             data[7:0]        - aligned byte (registered)
//             locked           - FSM is in LOCK (registered)
//             sync_loss        - one-cycle pulse when lock is lost
//             sync_loss_count  - lock-loss events, saturating at 255
//  Revision : 1.0 - initial release
// ============================================================================
module ts_sync_detector #(
    parameter int         PKT_LEN      = 188,
    parameter logic [7:0] SYNC_BYTE    = 8'h47,
    parameter int         LOCK_COUNT   = 5,
    parameter int         UNLOCK_COUNT = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       valid_in,
    input  logic [7:0] data_in,
    input  logic       en_reset_counter,
    output logic       valid,
    output logic       sync,
    output logic [7:0] data,
    output logic       locked,
    output logic       sync_loss,
    output logic [7:0] sync_loss_count
);

    localparam int c_good_w = $clog2(LOCK_COUNT + 1);
    localparam int c_bad_w  = $clog2(UNLOCK_COUNT + 1);

    localparam logic [c_good_w-1:0] c_lock_cnt   = c_good_w'(LOCK_COUNT);
    localparam logic [c_bad_w-1:0]  c_unlock_cnt = c_bad_w'(UNLOCK_COUNT);
    localparam logic [7:0]          c_last_pos   = 8'(PKT_LEN - 1);

    localparam logic [1:0] c_hunt   = 2'd0;
    localparam logic [1:0] c_verify = 2'd1;
    localparam logic [1:0] c_lock   = 2'd2;

    logic [1:0]          state_q,     state_d;
    logic [7:0]          pos_q,       pos_d;
    logic [c_good_w-1:0] good_cnt_q,  good_cnt_d;
    logic [c_bad_w-1:0]  bad_cnt_q,   bad_cnt_d;
    logic                valid_q,     valid_d;
    logic                sync_q,      sync_d;
    logic [7:0]          data_q,      data_d;
    logic                locked_q,    locked_d;
    logic                sync_loss_q, sync_loss_d;
    logic [7:0]          loss_cnt_q,  loss_cnt_d;

    logic                w_slot;
    logic                w_is_sync;
    logic [7:0]          w_pos_next;
    logic [c_good_w-1:0] w_good_inc;
    logic [c_bad_w-1:0]  w_bad_inc;
    logic                w_lock_done;
    logic                w_unlock;

    assign w_slot     = (pos_q == 8'd0);
    assign w_is_sync  = (data_in == SYNC_BYTE);
    assign w_pos_next = (pos_q == c_last_pos) ? 8'd0 : pos_q + 8'd1;
    assign w_good_inc = good_cnt_q + 1'b1;
    assign w_bad_inc  = bad_cnt_q + 1'b1;

    // The LOCK_COUNT-th good sync byte both completes lock and is forwarded.
    assign w_lock_done = valid_in && (state_q == c_verify) && w_slot &&
                         w_is_sync && (w_good_inc == c_lock_cnt);
    // The bad slot that exhausts the tolerance is swallowed, not forwarded.
    assign w_unlock    = valid_in && (state_q == c_lock) && w_slot &&
                         !w_is_sync && (w_bad_inc == c_unlock_cnt);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= c_hunt;
            pos_q       <= 8'd0;
            good_cnt_q  <= '0;
            bad_cnt_q   <= '0;
            valid_q     <= 1'b0;
            sync_q      <= 1'b0;
            data_q      <= 8'd0;
            locked_q    <= 1'b0;
            sync_loss_q <= 1'b0;
            loss_cnt_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            good_cnt_q  <= good_cnt_d;
            bad_cnt_q   <= bad_cnt_d;
            valid_q     <= valid_d;
            sync_q      <= sync_d;
            data_q      <= data_d;
            locked_q    <= locked_d;
            sync_loss_q <= sync_loss_d;
            loss_cnt_q  <= loss_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic: alignment FSM, packet position and run counters
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        pos_d      = pos_q;
        good_cnt_d = good_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        if (valid_in) begin
            case (state_q)
                c_hunt: begin
                    // The candidate sync byte is position 0, so the next
                    // accepted byte is position 1.
                    if (w_is_sync) begin
                        state_d    = c_verify;
                        pos_d      = 8'd1;
                        good_cnt_d = c_good_w'(1);
                    end
                end
                c_verify: begin
                    pos_d = w_pos_next;
                    if (w_slot) begin
                        if (w_is_sync) begin
                            good_cnt_d = w_good_inc;
                            if (w_lock_done) begin
                                state_d   = c_lock;
                                bad_cnt_d = '0;
                            end
                        end else begin
                            state_d    = c_hunt;
                            good_cnt_d = '0;
                            pos_d      = 8'd0;
                        end
                    end
                end
                c_lock: begin
                    pos_d = w_pos_next;
                    if (w_slot) begin
                        if (w_is_sync) begin
                            bad_cnt_d = '0;
                        end else if (w_unlock) begin
                            state_d    = c_hunt;
                            good_cnt_d = '0;
                            bad_cnt_d  = '0;
                            pos_d      = 8'd0;
                        end else begin
                            bad_cnt_d = w_bad_inc;
                        end
                    end
                end
                default: begin
                    state_d    = c_hunt;
                    pos_d      = 8'd0;
                    good_cnt_d = '0;
                    bad_cnt_d  = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output logic (registered through the state register process)
    // ------------------------------------------------------------------
    always_comb begin
        valid_d     = 1'b0;
        sync_d      = 1'b0;
        data_d      = data_q;
        locked_d    = (state_d == c_lock);
        sync_loss_d = w_unlock;
        // A tolerated bad slot is still marked sync to keep packet framing.
        if (w_lock_done || (valid_in && (state_q == c_lock) && !w_unlock)) begin
            valid_d = 1'b1;
            sync_d  = w_slot;
            data_d  = data_in;
        end
        if (en_reset_counter) begin
            loss_cnt_d = 8'd0;
        end else if (w_unlock && (loss_cnt_q != 8'hFF)) begin
            loss_cnt_d = loss_cnt_q + 8'd1;
        end else begin
            loss_cnt_d = loss_cnt_q;
        end
    end

    assign valid           = valid_q;
    assign sync            = sync_q;
    assign data            = data_q;
    assign locked          = locked_q;
    assign sync_loss       = sync_loss_q;
    assign sync_loss_count = loss_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ts_sync_detector.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ts_sync_detector
//  Purpose  : Directed self-checking bench for ts_sync_detector. Instance A
//             uses default parameters; instance B uses a 4-byte packet with
//             short lock/unlock runs to reach counter saturation quickly.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ts_sync_detector;

    logic       clk;
    logic       reset_n;
    logic       valid_in;
    logic [7:0] data_in;
    logic       en_reset_counter;
    logic       valid;
    logic       sync;
    logic [7:0] data;
    logic       locked;
    logic       sync_loss;
    logic [7:0] sync_loss_count;

    logic       b_valid_in;
    logic [7:0] b_data_in;
    logic       b_en;
    logic       b_valid;
    logic       b_sync;
    logic [7:0] b_data;
    logic       b_locked;
    logic       b_sync_loss;
    logic [7:0] b_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Per-scenario observation counters
    int         n_acc, first_lock, n_valid, n_sync, n_badsync, n_zero_sync;
    int         n_datamis, n_idle_valid, n_hold, n_loss, n_unlocked;
    int         n_valid_unlocked, b_loss;
    logic       first_sync, first_valid, prev_lk;
    logic [7:0] first_data, prev_out;

    ts_sync_detector u_dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .valid_in         (valid_in),
        .data_in          (data_in),
        .en_reset_counter (en_reset_counter),
        .valid            (valid),
        .sync             (sync),
        .data             (data),
        .locked           (locked),
        .sync_loss        (sync_loss),
        .sync_loss_count  (sync_loss_count)
    );

    ts_sync_detector #(
        .PKT_LEN      (4),
        .SYNC_BYTE    (8'h47),
        .LOCK_COUNT   (2),
        .UNLOCK_COUNT (1)
    ) u_dut_small (
        .clk              (clk),
        .reset_n          (reset_n),
        .valid_in         (b_valid_in),
        .data_in          (b_data_in),
        .en_reset_counter (b_en),
        .valid            (b_valid),
        .sync             (b_sync),
        .data             (b_data),
        .locked           (b_locked),
        .sync_loss        (b_sync_loss),
        .sync_loss_count  (b_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic clr();
        n_acc = 0; first_lock = 0; n_valid = 0; n_sync = 0; n_badsync = 0;
        n_zero_sync = 0; n_datamis = 0; n_idle_valid = 0; n_hold = 0;
        n_loss = 0; n_unlocked = 0; n_valid_unlocked = 0;
        first_sync = 1'b0; first_valid = 1'b0; first_data = 8'd0;
    endtask

    // Payload avoids 0x47 so only true sync slots can produce an alignment.
    function automatic logic [7:0] pay(input int i);
        logic [7:0] v;
        v = i[7:0];
        return (v == 8'h47) ? 8'hEE : v;
    endfunction

    // Drive one cycle on instance A and observe its registered response.
    task automatic step(input logic vin, input logic [7:0] d);
        valid_in = vin;
        data_in  = d;
        @(posedge clk);
        #1;
        if (vin) n_acc++;
        if (valid) begin
            n_valid++;
            if (data !== d) n_datamis++;
            if (sync) begin
                n_sync++;
                if (data != 8'h47) n_badsync++;
                if (data == 8'h00) n_zero_sync++;
            end
        end
        if (!vin && (valid || sync)) n_idle_valid++;
        if (!vin && (data !== prev_out)) n_hold++;
        if (sync_loss) n_loss++;
        if (!locked) n_unlocked++;
        if (valid && !locked) n_valid_unlocked++;
        if (locked && !prev_lk && first_lock == 0) begin
            first_lock  = n_acc;
            first_sync  = sync;
            first_valid = valid;
            first_data  = data;
        end
        prev_lk  = locked;
        prev_out = data;
        valid_in = 1'b0;
    endtask

    task automatic pkt(input logic [7:0] s, input bit gap);
        step(1'b1, s);
        if (gap) step(1'b0, 8'h47);
        for (int i = 0; i < 187; i++) begin
            step(1'b1, pay(i));
            if (gap) step(1'b0, 8'h47);
        end
    endtask

    task automatic step_b(input logic [7:0] d);
        b_valid_in = 1'b1;
        b_data_in  = d;
        @(posedge clk);
        #1;
        if (b_sync_loss) b_loss++;
    endtask

    // One lock (2 good slots) followed by a single bad slot on instance B.
    task automatic lock_lose_b();
        step_b(8'h47); step_b(8'h01); step_b(8'h02); step_b(8'h03);
        step_b(8'h47); step_b(8'h01); step_b(8'h02); step_b(8'h03);
        step_b(8'h00);
    endtask

    initial begin
        valid_in = 1'b0; data_in = 8'd0; en_reset_counter = 1'b0;
        b_valid_in = 1'b0; b_data_in = 8'd0; b_en = 1'b0;
        prev_lk = 1'b0; prev_out = 8'd0; b_loss = 0;
        clr();
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", int'({valid, sync, sync_loss, data, sync_loss_count}), 0);
        chk("reset_locked", int'(locked), 0);
        reset_n = 1'b1;

        // Clean stream, continuous valid_in
        clr();
        for (int p = 0; p < 10; p++) pkt(8'h47, 1'b0);
        chk("clean_lock_byte", first_lock, 753);
        chk("clean_first_valid", int'(first_valid), 1);
        chk("clean_first_sync", int'(first_sync), 1);
        chk("clean_first_data", int'(first_data), 8'h47);
        chk("clean_valid_bytes", n_valid, 6 * 188);
        chk("clean_sync_count", n_sync, 6);
        chk("clean_sync_not_47", n_badsync, 0);
        chk("clean_data_mismatch", n_datamis, 0);
        chk("clean_valid_unlocked", n_valid_unlocked, 0);

        // Asynchronous reset in the middle of a locked packet
        step(1'b1, 8'h47);
        for (int i = 0; i < 49; i++) step(1'b1, pay(i));
        chk("pre_reset_locked", int'(locked), 1);
        reset_n = 1'b0;
        #1;
        chk("async_reset_outputs",
            int'({valid, sync, locked, sync_loss, data, sync_loss_count}), 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Same stream with valid_in toggling 1,0,1,0
        clr();
        for (int p = 0; p < 10; p++) pkt(8'h47, 1'b1);
        chk("gap_lock_byte", first_lock, 753);
        chk("gap_first_sync", int'(first_sync), 1);
        chk("gap_valid_bytes", n_valid, 6 * 188);
        chk("gap_sync_count", n_sync, 6);
        chk("gap_data_mismatch", n_datamis, 0);
        chk("gap_idle_valid", n_idle_valid, 0);
        chk("gap_data_hold", n_hold, 0);

        // Two bad slots tolerated, then a good slot clears the run
        clr();
        pkt(8'h00, 1'b0); pkt(8'h00, 1'b0); pkt(8'h47, 1'b0);
        pkt(8'h00, 1'b0); pkt(8'h00, 1'b0); pkt(8'h47, 1'b0);
        chk("tol_unlocked_cycles", n_unlocked, 0);
        chk("tol_sync_loss", n_loss, 0);
        chk("tol_sync_count", n_sync, 6);
        chk("tol_zero_sync_fwd", n_zero_sync, 4);
        chk("tol_valid_bytes", n_valid, 6 * 188);

        // Three consecutive bad slots drop lock, clean stream relocks
        clr();
        pkt(8'h00, 1'b0); pkt(8'h00, 1'b0);
        step(1'b1, 8'h00);
        chk("loss_valid", int'(valid), 0);
        chk("loss_pulse", int'(sync_loss), 1);
        chk("loss_locked", int'(locked), 0);
        chk("loss_count", int'(sync_loss_count), 1);
        for (int i = 0; i < 187; i++) step(1'b1, pay(i));
        for (int p = 0; p < 5; p++) pkt(8'h47, 1'b0);
        chk("loss_pulse_total", n_loss, 1);
        chk("relock_byte", first_lock, 377 + 940);
        chk("relock_locked", int'(locked), 1);
        chk("relock_count", int'(sync_loss_count), 1);

        // False sync at payload offset 50 while hunting
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        clr();
        step(1'b1, 8'h00);
        for (int i = 0; i < 187; i++) step(1'b1, (i == 49) ? 8'h47 : pay(i));
        for (int p = 0; p < 7; p++) pkt(8'h47, 1'b0);
        chk("false_sync_lock_byte", first_lock, 1129);
        chk("false_sync_valid_unlocked", n_valid_unlocked, 0);
        chk("false_sync_valid_bytes", n_valid, 2 * 188);

        // Saturation and clear priority on the short-packet instance
        chk("sat_initial", int'(b_count), 0);
        for (int k = 0; k < 255; k++) lock_lose_b();
        chk("sat_at_255", int'(b_count), 255);
        lock_lose_b();
        chk("sat_hold_255", int'(b_count), 255);
        chk("sat_pulses", b_loss, 256);
        step_b(8'h47); step_b(8'h01); step_b(8'h02); step_b(8'h03);
        step_b(8'h47); step_b(8'h01); step_b(8'h02); step_b(8'h03);
        chk("clr_pre_locked", int'(b_locked), 1);
        b_en = 1'b1;
        step_b(8'h00);
        b_en = 1'b0;
        chk("clr_same_cycle_pulse", int'(b_sync_loss), 1);
        chk("clr_wins", int'(b_count), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
